return_addr_stack: RTL
======================

Name: return_addr_stack

Overview:
Hardware return-address stack for the single-cycle core. It sits directly upstream of the next-PC select.
- On a call, the controller pushes PC+1.
- On a return, the controller pops, and the top entry feeds the next-PC mux in that same cycle.
- It adds full/empty status, circular overflow handling and sticky error flags so call-depth faults are visible to software and the bench.

Parameters:
ADDR_W, 12, width of a stored return address (matches the PC width)
DEPTH, 8, number of entries; power of two, minimum 2
PTR_W, $clog2(DEPTH), width of the top-of-stack pointer

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
push  in  1  store push_addr as the new top at the next edge
pop  in  1  discard the top entry at the next edge
push_addr  in  ADDR_W  return address to store (PC+1)
clear_err  in  1  synchronous clear of the sticky error flags
top_addr  out  ADDR_W  current top entry (combinational read); 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  PTR_W+1  number of valid entries
overflow  out  1  sticky: a push occurred while full
underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Reset is asynchronous and active-low (rst = 0). It forces:
  - tos pointer = 0 and count = 0
  - overflow = 0 and underflow = 0
  - top_addr = 0, empty = 1, full = 0
  - Storage contents are not reset and may hold any value.
- Reset asserted mid-operation aborts any push or pop in flight. No partial write is kept.
- top_addr:
  - Combinational read of mem[tos-1 mod DEPTH] when count > 0, otherwise 0.
  - Zero latency, so a return uses the value in the same cycle pop is high.
- Push only (push=1, pop=0):
  - mem[tos] <= push_addr and tos <= tos+1 (mod DEPTH).
  - count increments, saturating at DEPTH.
  - If already full: the write overwrites the oldest entry (circular wrap), count stays DEPTH, and overflow is set.
- Pop only (push=0, pop=1):
  - If count > 0: tos <= tos-1 (mod DEPTH) and count decrements.
  - If empty: no state change except underflow is set; top_addr stays 0.
- Push and pop together:
  - If count > 0: replace the top (mem[tos-1] <= push_addr); tos and count are unchanged; no flags.
  - If empty: behaves as a push only, and underflow is set.
- Neither asserted: hold all state.
- Error flag priority: clear_err clears both flags at the edge, but a new error in the same cycle wins and leaves that flag set.
- Updated status (count, empty, full, top_addr) is visible from the cycle after the edge.
- Wrap-around: tos indexes modulo DEPTH in both directions. After an overflow, popping DEPTH times returns the DEPTH newest addresses, newest first; older entries are lost.

Decomposition:
- Package ras_pkg holds:
  - localparams ADDR_W=12 and RAS_DEPTH=8
  - typedef ras_addr_t (logic [ADDR_W-1:0])
  - typedef ras_op_e enum {RAS_NOP, RAS_PUSH, RAS_POP, RAS_REPLACE}, decoded from {push, pop}
- One sub-module, ras_storage: a DEPTH x ADDR_W register array with a single write port (we, waddr, wdata) and one combinational read port.
- Pointer, count and flag logic stay in return_addr_stack.

Test Plan:
- Reset with rst=0, then push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top_addr=0x030, empty=0, full=0.
- Three pops from that state -> top_addr reads 0x030, 0x020, 0x010 in the pop cycles; then empty=1, top_addr=0x000, no flags.
- Push 9 addresses 0x101..0x109 with DEPTH=8 -> full=1, overflow=1 after the 9th. Eight pops yield 0x109 down to 0x102, then empty=1.
- Pop on empty -> underflow=1, count=0. Then clear_err with no new error -> underflow=0 on the next cycle.
- With count=2 and top 0x0AA, assert push and pop together with push_addr=0x0BB -> count=2, top_addr=0x0BB. Then a pop exposes the older entry.
- Assert rst=0 asynchronously mid-cycle while count=5 and overflow=1 -> count=0, empty=1, overflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types for the return-address stack: address type and the
// operation decoded from the {push, pop} request pair.
package ras_pkg;

  localparam int ADDR_W    = 12;
  localparam int RAS_DEPTH = 8;

  typedef logic [ADDR_W-1:0] ras_addr_t;

  // Encoding matches {push, pop} so the decode is a direct cast.
  typedef enum logic [1:0] {
    RAS_NOP     = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSH    = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

endpackage

// File: rtl/ras_storage.sv
// Return-address storage: DEPTH x ADDR_W register array, one write port,
// one combinational read port. Contents are intentionally not reset.
module ras_storage #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Zero-latency read so a return can use the top entry in the pop cycle.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack feeding next-PC select: circular storage with
// count/full/empty status and sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  import ras_pkg::*;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  tos_reg, tos_next;
  logic [PTR_W:0]    count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              ov_set, un_set;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] rdata;
  logic              is_empty, is_full;
  ras_op_e           op;

  assign op       = ras_op_e'({push, pop});
  assign top_idx  = tos_reg - PTR_ONE;
  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CNT_FULL);

  always_comb begin
    tos_next   = tos_reg;
    count_next = count_reg;
    we         = 1'b0;
    waddr      = tos_reg;
    ov_set     = 1'b0;
    un_set     = 1'b0;
    case (op)
      RAS_PUSH: begin
        // When full the write lands on the oldest slot and count saturates.
        we       = 1'b1;
        tos_next = tos_reg + PTR_ONE;
        if (is_full) begin
          ov_set = 1'b1;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      RAS_POP: begin
        if (!is_empty) begin
          tos_next   = tos_reg - PTR_ONE;
          count_next = count_reg - CNT_ONE;
        end else begin
          un_set = 1'b1;
        end
      end
      RAS_REPLACE: begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = top_idx;
        end else begin
          tos_next   = tos_reg + PTR_ONE;
          count_next = count_reg + CNT_ONE;
          un_set     = 1'b1;
        end
      end
      default: ;
    endcase
    // A fresh error in the same cycle beats the clear.
    overflow_next  = (overflow_reg  & ~clear_err) | ov_set;
    underflow_next = (underflow_reg & ~clear_err) | un_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_reg       <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      tos_reg       <= tos_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Writes are suppressed while reset is held so no partial update survives.
  ras_storage #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we & rst),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign top_addr  = is_empty ? '0 : rdata;
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
